adder_exhaustive_eval: RTL and testbench

//   Sequential test harness that sits around the 7-bit adder benchmark.
//   It drives all 2^15 input vectors into the adder, one per cycle.
//   It compares each 8-bit result against a built-in golden model and

---
 rtl/adder_exhaustive_eval.sv | 208 ++++++++++++++++++++
 tb/tb_adder_exhaustive_eval.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_exhaustive_eval.sv
// adder_exhaustive_eval: exhaustive sweep harness around the 7-bit adder benchmark; counts result mismatches.
// Latency: 2^IN_W + PIPE_LAT + 1 cycles from the start pulse to done; err_count is final when done rises.
// Backpressure: none; one vector is issued per cycle and start is ignored while busy.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset; aborts any sweep in progress
//   start      one-cycle pulse that begins a sweep (accepted in IDLE or DONE only)
//   vec_out    registered stimulus, vec_out[i] drives adder input pi{i}
//   dut_res    adder response, dut_res[j] = po{j}
//   busy       high in RUN and DRAIN
//   done       high in DONE until the next start
//   err_count  saturating count of mismatching vectors (the fitness figure)
// Optional: define ADDER_EVAL_FIRSTERR_EN to add first_err_vec / first_err_vld, which latch the
// index of the first failing vector of a sweep until the next start or reset.
`timescale 1ns/1ps
module adder_exhaustive_eval #(
   parameter int IN_W     = 15,
   parameter int OUT_W    = 8,
   parameter int PIPE_LAT = 0,
   parameter int CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   output logic [IN_W-1:0]  vec_out,
   input  logic [OUT_W-1:0] dut_res,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] err_count
`ifdef ADDER_EVAL_FIRSTERR_EN
   ,
   output logic [IN_W-1:0]  first_err_vec,
   output logic             first_err_vld
`endif
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   // DRAIN lasts PIPE_LAT+1 cycles: PIPE_LAT for the last response to emerge, one for the
   // registered compare, so the final count update coincides with entering DONE.
   localparam int DRN_W = $clog2(PIPE_LAT + 2);

   state_t           state_q, state_d;
   logic [IN_W-1:0]  vec_q, vec_d;
   logic [DRN_W-1:0] drain_q, drain_d;
   logic             start_acc;

   logic             cur_vld;
   logic [6:0]       gm_a, gm_b;
   logic [7:0]       gm_s;
   logic [OUT_W-1:0] exp_res;

   logic [OUT_W-1:0] exp_dly;
   logic             vld_dly;
   logic             mis_q;
   logic [CNT_W-1:0] err_q;

   // ---------------- sweep FSM ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         vec_q   <= '0;
         drain_q <= '0;
      end else begin
         state_q <= state_d;
         vec_q   <= vec_d;
         drain_q <= drain_d;
      end
   end

   // vec_d defaults to 0, so the stimulus is 0 on entering RUN and wraps to 0 on leaving it.
   always_comb begin
      state_d   = state_q;
      vec_d     = '0;
      drain_d   = '0;
      start_acc = 1'b0;
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d   = RUN;
               start_acc = 1'b1;
            end
         end
         RUN: begin
            if (vec_q == '1) state_d = DRAIN;
            else             vec_d   = vec_q + IN_W'(1);
         end
         DRAIN: begin
            if (drain_q == DRN_W'(PIPE_LAT)) state_d = DONE;
            else                             drain_d = drain_q + DRN_W'(1);
         end
         default: state_d = IDLE;
      endcase
   end

   assign vec_out   = vec_q;
   assign busy      = (state_q == RUN) || (state_q == DRAIN);
   assign done      = (state_q == DONE);
   assign cur_vld   = (state_q == RUN);

   // ---------------- golden model ----------------
   // Operand bits are taken MSB first from the stimulus; the benchmark's outputs are
   // bit-reversed relative to the sum (po0 = carry-out, po7 = LSB).
   always_comb begin
      gm_a = {vec_q[0], vec_q[1], vec_q[2], vec_q[3], vec_q[4], vec_q[5], vec_q[13]};
      gm_b = {vec_q[6], vec_q[7], vec_q[8], vec_q[9], vec_q[10], vec_q[11], vec_q[14]};
      gm_s = {1'b0, gm_a} + {1'b0, gm_b} + {7'd0, vec_q[12]};
      exp_res = '0;
      for (int j = 0; j < OUT_W; j++) begin
         exp_res[j] = gm_s[OUT_W-1-j];
      end
   end

   // ---------------- expected-value delay line ----------------
`ifdef ADDER_EVAL_FIRSTERR_EN
   logic [IN_W-1:0] idx_dly;
`endif

   generate
      if (PIPE_LAT == 0) begin : g_nodly
         assign exp_dly = exp_res;
         assign vld_dly = cur_vld;
`ifdef ADDER_EVAL_FIRSTERR_EN
         assign idx_dly = vec_q;
`endif
      end else begin : g_dly
         logic [OUT_W-1:0] exp_pipe_q [PIPE_LAT];
         logic             vld_pipe_q [PIPE_LAT];
`ifdef ADDER_EVAL_FIRSTERR_EN
         logic [IN_W-1:0]  idx_pipe_q [PIPE_LAT];
`endif
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               for (int i = 0; i < PIPE_LAT; i++) begin
                  exp_pipe_q[i] <= '0;
                  vld_pipe_q[i] <= 1'b0;
`ifdef ADDER_EVAL_FIRSTERR_EN
                  idx_pipe_q[i] <= '0;
`endif
               end
            end else begin
               exp_pipe_q[0] <= exp_res;
               vld_pipe_q[0] <= cur_vld;
`ifdef ADDER_EVAL_FIRSTERR_EN
               idx_pipe_q[0] <= vec_q;
`endif
               for (int i = 1; i < PIPE_LAT; i++) begin
                  exp_pipe_q[i] <= exp_pipe_q[i-1];
                  vld_pipe_q[i] <= vld_pipe_q[i-1];
`ifdef ADDER_EVAL_FIRSTERR_EN
                  idx_pipe_q[i] <= idx_pipe_q[i-1];
`endif
               end
            end
         end
         assign exp_dly = exp_pipe_q[PIPE_LAT-1];
         assign vld_dly = vld_pipe_q[PIPE_LAT-1];
`ifdef ADDER_EVAL_FIRSTERR_EN
         assign idx_dly = idx_pipe_q[PIPE_LAT-1];
`endif
      end
   endgenerate

   // ---------------- registered compare and saturating count ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mis_q <= 1'b0;
         err_q <= '0;
      end else begin
         mis_q <= vld_dly && (dut_res != exp_dly);
         if (start_acc) begin
            err_q <= '0;
         end else if (mis_q && (err_q != '1)) begin
            err_q <= err_q + CNT_W'(1);
         end
      end
   end

   assign err_count = err_q;

`ifdef ADDER_EVAL_FIRSTERR_EN
   // The index travels one stage alongside the compare so it lines up with mis_q.
   logic [IN_W-1:0] mis_idx_q, ferr_vec_q;
   logic            ferr_vld_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mis_idx_q  <= '0;
         ferr_vec_q <= '0;
         ferr_vld_q <= 1'b0;
      end else begin
         mis_idx_q <= idx_dly;
         if (start_acc) begin
            ferr_vec_q <= '0;
            ferr_vld_q <= 1'b0;
         end else if (mis_q && !ferr_vld_q) begin
            ferr_vec_q <= mis_idx_q;
            ferr_vld_q <= 1'b1;
         end
      end
   end

   assign first_err_vec = ferr_vec_q;
   assign first_err_vld = ferr_vld_q;
`endif

endmodule

// File: tb/tb_adder_exhaustive_eval.sv
// tb_adder_exhaustive_eval: six harness instances run side by side against different adder models
// (correct, po7 stuck-at-0, po0 inverted, po0 inverted with a 15-bit counter, 2-stage registered
// adder with matching and with zero PIPE_LAT). Expected results are queued per sweep and popped
// by a monitor whenever an instance raises done.
`timescale 1ns/1ps
module tb_adder_exhaustive_eval;

   localparam int NI = 6;
   localparam int NV = 32768;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;

   logic [14:0]   vec_a [NI];
   logic [7:0]    res_a [NI];
   logic [NI-1:0] busy_a;
   logic [NI-1:0] done_a;
   logic [15:0]   err_a [NI];
   logic [14:0]   err_sat;
   logic [7:0]    p2_a, p2_b, mis_a, mis_b;
`ifdef ADDER_EVAL_FIRSTERR_EN
   logic [14:0]   fvec_a [NI];
   logic [NI-1:0] fvld_a;
`endif

   int cyc        = 0;
   int start_edge = 0;
   int n_chk      = 0;
   int n_pass     = 0;
   int mis_exp    = 0;
   bit sweep_live = 1'b0;

   typedef struct {
      int inst;
      int err;
      int lat;
   } exp_t;
   exp_t sb[$];

   // Reference adder response: A/B/cin assembled with weights, sum bit-reversed onto po0..po7.
   function automatic logic [7:0] resp(input logic [14:0] v);
      int a, b, s;
      logic [7:0] s8;
      a = 64*v[0] + 32*v[1] + 16*v[2] + 8*v[3] + 4*v[4] + 2*v[5] + int'(v[13]);
      b = 64*v[6] + 32*v[7] + 16*v[8] + 8*v[9] + 4*v[10] + 2*v[11] + int'(v[14]);
      s = a + b + int'(v[12]);
      s8 = 8'(s);
      return {<<{s8}};
   endfunction

   initial forever #5 clk = ~clk;
   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // ---------------- adder models ----------------
   always @(posedge clk) begin
      p2_a  <= resp(vec_a[4]);
      p2_b  <= p2_a;
      mis_a <= resp(vec_a[5]);
      mis_b <= mis_a;
   end

   always_comb begin
      res_a[0] = resp(vec_a[0]);
      res_a[1] = resp(vec_a[1]) & 8'h7F;
      res_a[2] = resp(vec_a[2]) ^ 8'h01;
      res_a[3] = resp(vec_a[3]) ^ 8'h01;
      res_a[4] = p2_b;
      res_a[5] = mis_b;
   end

   assign err_a[3] = {1'b0, err_sat};

   // ---------------- instances ----------------
   adder_exhaustive_eval u_ok (
      .clk(clk), .rst_n(rst_n), .start(start), .vec_out(vec_a[0]), .dut_res(res_a[0]),
      .busy(busy_a[0]), .done(done_a[0]), .err_count(err_a[0])
`ifdef ADDER_EVAL_FIRSTERR_EN
      , .first_err_vec(fvec_a[0]), .first_err_vld(fvld_a[0])
`endif
   );

   adder_exhaustive_eval u_s7 (
      .clk(clk), .rst_n(rst_n), .start(start), .vec_out(vec_a[1]), .dut_res(res_a[1]),
      .busy(busy_a[1]), .done(done_a[1]), .err_count(err_a[1])
`ifdef ADDER_EVAL_FIRSTERR_EN
      , .first_err_vec(fvec_a[1]), .first_err_vld(fvld_a[1])
`endif
   );

   adder_exhaustive_eval u_i0 (
      .clk(clk), .rst_n(rst_n), .start(start), .vec_out(vec_a[2]), .dut_res(res_a[2]),
      .busy(busy_a[2]), .done(done_a[2]), .err_count(err_a[2])
`ifdef ADDER_EVAL_FIRSTERR_EN
      , .first_err_vec(fvec_a[2]), .first_err_vld(fvld_a[2])
`endif
   );

   adder_exhaustive_eval #(.CNT_W(15)) u_sat (
      .clk(clk), .rst_n(rst_n), .start(start), .vec_out(vec_a[3]), .dut_res(res_a[3]),
      .busy(busy_a[3]), .done(done_a[3]), .err_count(err_sat)
`ifdef ADDER_EVAL_FIRSTERR_EN
      , .first_err_vec(fvec_a[3]), .first_err_vld(fvld_a[3])
`endif
   );

   adder_exhaustive_eval #(.PIPE_LAT(2)) u_p2 (
      .clk(clk), .rst_n(rst_n), .start(start), .vec_out(vec_a[4]), .dut_res(res_a[4]),
      .busy(busy_a[4]), .done(done_a[4]), .err_count(err_a[4])
`ifdef ADDER_EVAL_FIRSTERR_EN
      , .first_err_vec(fvec_a[4]), .first_err_vld(fvld_a[4])
`endif
   );

   adder_exhaustive_eval u_mis (
      .clk(clk), .rst_n(rst_n), .start(start), .vec_out(vec_a[5]), .dut_res(res_a[5]),
      .busy(busy_a[5]), .done(done_a[5]), .err_count(err_a[5])
`ifdef ADDER_EVAL_FIRSTERR_EN
      , .first_err_vec(fvec_a[5]), .first_err_vld(fvld_a[5])
`endif
   );

   // ---------------- helpers ----------------
   task automatic chk(input string name, input longint act, input longint req);
      n_chk++;
      if (act == req) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
   endtask

   task automatic check_quiet(input string tag);
      for (int i = 0; i < NI; i++) begin
         chk($sformatf("%s busy[%0d]", tag, i), longint'(busy_a[i]), 0);
         chk($sformatf("%s done[%0d]", tag, i), longint'(done_a[i]), 0);
         chk($sformatf("%s err_count[%0d]", tag, i), longint'(err_a[i]), 0);
         chk($sformatf("%s vec_out[%0d]", tag, i), longint'(vec_a[i]), 0);
`ifdef ADDER_EVAL_FIRSTERR_EN
         chk($sformatf("%s first_err_vld[%0d]", tag, i), longint'(fvld_a[i]), 0);
         chk($sformatf("%s first_err_vec[%0d]", tag, i), longint'(fvec_a[i]), 0);
`endif
      end
   endtask

   // Hand-derived sweep results: a correct adder never mismatches; po7 (sum LSB) stuck at 0
   // fails on every odd sum, i.e. half of all vectors; an inverted carry-out fails everywhere,
   // saturating a 15-bit counter; the 2-stage adder takes 2 extra drain cycles.
   task automatic push_sweep();
      sb.push_back(exp_t'{0, 0,       NV + 1});
      sb.push_back(exp_t'{1, 16384,   NV + 1});
      sb.push_back(exp_t'{2, 32768,   NV + 1});
      sb.push_back(exp_t'{3, 32767,   NV + 1});
      sb.push_back(exp_t'{4, 0,       NV + 3});
      sb.push_back(exp_t'{5, mis_exp, NV + 1});
   endtask

   task automatic pulse_start(input bit upd, input bit chk_after);
      @(posedge clk);
      #1;
      start = 1'b1;
      if (upd) begin
         start_edge = cyc + 1;
         sweep_live = 1'b1;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      if (chk_after) begin
         for (int i = 0; i < NI; i++) begin
            chk($sformatf("start busy[%0d]", i), longint'(busy_a[i]), 1);
            chk($sformatf("start done[%0d]", i), longint'(done_a[i]), 0);
            chk($sformatf("start err_count[%0d]", i), longint'(err_a[i]), 0);
         end
      end
   endtask

   task automatic wait_sb();
      int n = 0;
      while (sb.size() != 0 && n < 2*NV) begin
         @(negedge clk);
         n++;
      end
      chk("sweep_completes pending", longint'(sb.size()), 0);
      sweep_live = 1'b0;
   endtask

   task automatic check_done(input int i, input int bcnt);
      int idx = -1;
      for (int j = 0; j < sb.size(); j++) begin
         if (sb[j].inst == i) begin
            idx = j;
            break;
         end
      end
      chk($sformatf("done_expected[%0d]", i), longint'(idx >= 0), 1);
      if (idx >= 0) begin
         chk($sformatf("err_count[%0d]", i), longint'(err_a[i]), longint'(sb[idx].err));
         chk($sformatf("done_latency[%0d]", i), longint'(cyc - start_edge), longint'(sb[idx].lat));
         chk($sformatf("busy_cycles[%0d]", i), longint'(bcnt), longint'(sb[idx].lat));
         chk($sformatf("vec_out_in_done[%0d]", i), longint'(vec_a[i]), 0);
`ifdef ADDER_EVAL_FIRSTERR_EN
         if (i == 1) begin
            chk("first_err_vec[1]", longint'(fvec_a[1]), longint'(15'h1000));
            chk("first_err_vld[1]", longint'(fvld_a[1]), 1);
         end
         if (i == 0) chk("first_err_vld[0]", longint'(fvld_a[0]), 0);
`endif
         sb.delete(idx);
      end
   endtask

   // ---------------- monitor ----------------
   initial begin
      int busy_cnt [NI];
      bit done_prev [NI];
      int k;
      for (int i = 0; i < NI; i++) begin
         busy_cnt[i]  = 0;
         done_prev[i] = 1'b0;
      end
      forever begin
         @(negedge clk);
         for (int i = 0; i < NI; i++) begin
            if (!rst_n) begin
               busy_cnt[i]  = 0;
               done_prev[i] = 1'b0;
            end else begin
               if (busy_a[i]) busy_cnt[i]++;
               if (done_a[i] && !done_prev[i]) begin
                  check_done(i, busy_cnt[i]);
                  busy_cnt[i] = 0;
               end
               done_prev[i] = done_a[i];
            end
         end
         if (rst_n && sweep_live) begin
            k = cyc - start_edge;
            for (int i = 0; i < NI; i++) begin
               if (k == 0 || k == 1 || k == 100 || k == NV - 1)
                  chk($sformatf("vec_out[%0d]@%0d", i, k), longint'(vec_a[i]), longint'(k));
               else if (k == NV)
                  chk($sformatf("vec_out_wrap[%0d]", i), longint'(vec_a[i]), 0);
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      // Misaligned case: the response seen in RUN cycle k belongs to vector k-2 (0 before the sweep).
      for (int v = 0; v < NV; v++) begin
         if (resp(15'(v)) != resp(15'((v >= 2) ? v - 2 : 0))) mis_exp++;
      end

      repeat (3) @(posedge clk);
      #1;
      check_quiet("reset");
      rst_n = 1'b1;
      repeat (2) @(posedge clk);

      // Sweep 1, with a stray start pulse around cycle 100 that must be ignored.
      push_sweep();
      pulse_start(1'b1, 1'b1);
      while (cyc < start_edge + 99) @(posedge clk);
      pulse_start(1'b0, 1'b0);
      wait_sb();

      // Sweep 2 restarts from DONE and is aborted by reset at cycle 5000.
      pulse_start(1'b1, 1'b1);
      while (cyc < start_edge + 5000) @(posedge clk);
      #1;
      sweep_live = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      check_quiet("abort");
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Sweep 3 must give full counts with nothing left over from the aborted sweep.
      push_sweep();
      pulse_start(1'b1, 1'b1);
      wait_sb();

      repeat (2) @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #1500000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $display("%0d/%0d checks passed", n_pass, n_chk + 1);
      $fatal(1, "watchdog");
   end

endmodule
